mcpu_soc_intc: RTL

Parametrised interrupt controller for the MCPU SoC interior. It replaces the tied-off int_pending/int_type core inputs with N maskable sources, each selectable as edge or level. It drives the core interrupt interface and consumes int_clear as acknowledge. It sits on the dl1c2periph MMIO bus alongside the existing peripherals, with software-visible pending, enable, mode and trigger registers.

---
 rtl/mcpu_soc_intc.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mcpu_soc_intc.sv
`default_nettype none
// ============================================================================
// Module   : mcpu_soc_intc
// Purpose  : Interrupt controller for the MCPU SoC interior. Collects
//            NUM_SRC maskable sources and drives the core int_pending /
//            int_type interface, taking int_clear as the acknowledge.
//            Each source is edge or level mode. The controller is
//            software visible on the dl1c2periph MMIO bus.
// Ports    : clkrst_core_clk/rst - core clock, synchronous active-high reset
//            irq_src               - raw request lines (asynchronous)
//            mmio_*                - word-indexed register access, byte enables
//            int_pending/int_type  - registered request to the core
//            int_clear             - one-cycle acknowledge from the core
// Regs     : 0 PEND (W1C, edge only), 1 ENABLE, 2 EDGE,
//            3 ACTIVE (RO: bit31 pending, low bits type), 4 SET (WO)
// Revision : 1.0 - initial release
// ============================================================================
module mcpu_soc_intc #(
  parameter int NUM_SRC     = 16,
  parameter int TYPE_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clkrst_core_clk,
  input  logic               clkrst_core_rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [2:0]         mmio_addr,
  input  logic               mmio_re,
  input  logic [3:0]         mmio_we,
  input  logic [31:0]        mmio_data_in,
  output logic [31:0]        mmio_data_out,
  output logic               int_pending,
  output logic [TYPE_W-1:0]  int_type,
  input  logic               int_clear
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_ACK     = 2'd2
  } state_t;

  localparam logic [2:0] c_ADDR_PEND   = 3'd0;
  localparam logic [2:0] c_ADDR_ENABLE = 3'd1;
  localparam logic [2:0] c_ADDR_EDGE   = 3'd2;
  localparam logic [2:0] c_ADDR_ACTIVE = 3'd3;
  localparam logic [2:0] c_ADDR_SET    = 3'd4;

  logic [NUM_SRC-1:0] w_s;
  logic [NUM_SRC-1:0] r_s_prev;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] r_enable;
  logic [NUM_SRC-1:0] r_edge;
  logic [NUM_SRC-1:0] w_pend;
  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] w_w1c;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_ack_clr;
  logic [NUM_SRC-1:0] w_type_onehot;
  logic [NUM_SRC-1:0] w_wmask;
  logic [NUM_SRC-1:0] w_wdata;
  logic [31:0]        w_wmask32;
  logic [31:0]        w_rdata;
  logic [31:0]        r_data_out;
  logic [TYPE_W-1:0]  w_winner;
  logic [TYPE_W-1:0]  r_int_type;
  logic [TYPE_W-1:0]  w_type_nxt;
  logic               r_int_pending;
  logic               w_pending_nxt;
  logic               w_wr;
  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_unused;

  // --------------------------------------------------------------------------
  // Input synchroniser
  // --------------------------------------------------------------------------
  if (SYNC_STAGES > 0) begin : g_sync
    logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];

    always_ff @(posedge clkrst_core_clk) begin
      if (clkrst_core_rst) begin
        for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      end else begin
        r_sync[0] <= irq_src;
        for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      end
    end

    assign w_s = r_sync[SYNC_STAGES-1];
  end else begin : g_nosync
    assign w_s = irq_src;
  end

  assign w_rise = w_s & ~r_s_prev;

  // --------------------------------------------------------------------------
  // Write decode
  // --------------------------------------------------------------------------
  assign w_wmask32 = {{8{mmio_we[3]}}, {8{mmio_we[2]}}, {8{mmio_we[1]}}, {8{mmio_we[0]}}};
  assign w_wmask   = w_wmask32[NUM_SRC-1:0];
  assign w_wdata   = mmio_data_in[NUM_SRC-1:0];
  assign w_wr      = |mmio_we;
  // Bits above NUM_SRC are architecturally ignored on write.
  assign w_unused  = ^{mmio_data_in, w_wmask32};

  assign w_w1c = (w_wr && mmio_addr == c_ADDR_PEND) ? (w_wdata & w_wmask) : '0;
  assign w_set = (w_wr && mmio_addr == c_ADDR_SET)  ? (w_wdata & w_wmask) : '0;

  assign w_type_onehot = NUM_SRC'(1) << r_int_type;
  assign w_ack_clr     = (r_state == ST_PRESENT && int_clear) ? w_type_onehot : '0;

  // Level sources bypass the latch so they track s with no extra delay;
  // r_pend only holds state for edge-mode bits.
  assign w_pend = (r_pend & r_edge) | (w_s & ~r_edge);
  assign w_elig = w_pend & r_enable;

  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      r_s_prev <= '0;
      r_pend   <= '0;
      r_enable <= '0;
      r_edge   <= '0;
    end else begin
      r_s_prev <= w_s;
      // Set terms are ORed after the clear so a coincident set wins.
      r_pend   <= r_edge & (w_rise | w_set | (r_pend & ~(w_w1c | w_ack_clr)));
      if (w_wr && mmio_addr == c_ADDR_ENABLE)
        r_enable <= (r_enable & ~w_wmask) | (w_wdata & w_wmask);
      if (w_wr && mmio_addr == c_ADDR_EDGE)
        r_edge <= (r_edge & ~w_wmask) | (w_wdata & w_wmask);
    end
  end

  // --------------------------------------------------------------------------
  // Fixed-priority winner: lowest index wins, so scan from the top down.
  // --------------------------------------------------------------------------
  always_comb begin
    w_winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_winner = TYPE_W'(i);
    end
  end

  // --------------------------------------------------------------------------
  // Presentation state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      r_state       <= ST_IDLE;
      r_int_pending <= 1'b0;
      r_int_type    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_int_pending <= w_pending_nxt;
      r_int_type    <= w_type_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_int_pending;
    w_type_nxt    = r_int_type;
    case (r_state)
      ST_IDLE: begin
        w_pending_nxt = 1'b0;
        if (|w_elig) begin
          w_type_nxt    = w_winner;
          w_pending_nxt = 1'b1;
          w_state_nxt   = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        // int_type stays frozen here regardless of newer requests.
        if (int_clear) begin
          w_pending_nxt = 1'b0;
          w_state_nxt   = ST_ACK;
        end else if (!(|(w_elig & w_type_onehot))) begin
          w_pending_nxt = 1'b0;
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_ACK: begin
        // Guaranteed low cycle between back-to-back presentations.
        w_pending_nxt = 1'b0;
        w_state_nxt   = ST_IDLE;
      end
      default: begin
        w_pending_nxt = 1'b0;
        w_state_nxt   = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  always_comb begin
    w_rdata = '0;
    case (mmio_addr)
      c_ADDR_PEND:   w_rdata[NUM_SRC-1:0] = w_pend;
      c_ADDR_ENABLE: w_rdata[NUM_SRC-1:0] = r_enable;
      c_ADDR_EDGE:   w_rdata[NUM_SRC-1:0] = r_edge;
      c_ADDR_ACTIVE: begin
        w_rdata[31]         = r_int_pending;
        w_rdata[TYPE_W-1:0] = r_int_type;
      end
      default:       w_rdata = '0;
    endcase
  end

  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      r_data_out <= '0;
    end else if (mmio_re) begin
      r_data_out <= w_rdata;
    end
  end

  assign mmio_data_out = r_data_out;
  assign int_pending   = r_int_pending;
  assign int_type      = r_int_type;

endmodule
`default_nettype wire
